// File: rtl/audio_pkg.sv
// Shared audio definitions for the sample path.
//   SAMPLE_W     - sample and PWM resolution in bits
//   MIDSCALE     - duty used for silence when no sample is available
//   sample_t     - unsigned audio sample
//   UNDERRUN_MAX - saturation value of the underrun counter
package audio_pkg;

  localparam int unsigned SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t    MIDSCALE     = 8'd128;
  localparam logic [7:0] UNDERRUN_MAX = 8'd255;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for audio samples.
//   clk    - system clock
//   n_rst  - synchronous active-high reset, empties the FIFO
//   push   - write wdata (ignored when full)
//   wdata  - data to write
//   pop    - advance the head (ignored when empty)
//   rdata  - head entry, valid while !empty
//   full   - no free entries
//   empty  - no entries
//   fill   - current occupancy
module sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0] fill_q;
  logic             do_push, do_pop;

  // Occupancy counter disambiguates full from empty when pointers coincide.
  assign empty   = (fill_q == '0);
  assign full    = (fill_q == FillW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign fill    = fill_q;

  // Storage carries no reset; stale entries are unreachable once fill is zero.
  always_ff @(posedge clk) begin
    if (do_push && !n_rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/sample_player.sv
// Sample player: buffers mixer samples and renders one per sample strobe as
// single-bit PWM, flagging strobes that find the buffer empty.
//   clk          - system clock
//   n_rst        - synchronous active-high reset
//   sample_now   - one-cycle sample strobe (nominally every 256 clk)
//   wr_data      - unsigned sample from the mixer
//   wr_valid     - wr_data valid
//   wr_ready     - FIFO can accept a push
//   fill         - current FIFO occupancy
//   pwm_out      - PWM audio output
//   underrun     - one-cycle pulse after a strobe hit an empty FIFO
//   underrun_cnt - saturating underrun count
module sample_player #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SAMPLE_W = 8   // fixed at 8 in this revision
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        sample_now,
  input  logic [SAMPLE_W-1:0]         wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic [$clog2(DEPTH+1)-1:0]  fill,
  output logic                        pwm_out,
  output logic                        underrun,
  output logic [7:0]                  underrun_cnt
);

  import audio_pkg::*;

  logic    fifo_full, fifo_empty;
  sample_t head;
  logic    push, pop, ur_event;

  sample_t    duty_q, duty_d;
  sample_t    pwm_cnt_q, pwm_cnt_d;
  logic       underrun_q, underrun_d;
  logic [7:0] ur_cnt_q, ur_cnt_d;

  // Ready comes from registered state only, so it never depends on wr_valid.
  assign wr_ready = !fifo_full && !n_rst;
  assign push     = wr_valid && wr_ready;
  assign pop      = sample_now && !fifo_empty && !n_rst;
  // A push landing on the same edge does not rescue an empty FIFO (no bypass).
  assign ur_event = sample_now && fifo_empty && !n_rst;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  always_comb begin
    duty_d     = duty_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    underrun_d = ur_event;
    ur_cnt_d   = ur_cnt_q;
    if (pop) begin
      duty_d = head;
    end else if (ur_event) begin
      duty_d = MIDSCALE;
    end
    // Every strobe restarts the frame, whatever the strobe period.
    if (sample_now) begin
      pwm_cnt_d = '0;
    end
    if (ur_event && (ur_cnt_q != UNDERRUN_MAX)) begin
      ur_cnt_d = ur_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      duty_q     <= MIDSCALE;
      pwm_cnt_q  <= '0;
      underrun_q <= 1'b0;
      ur_cnt_q   <= '0;
    end else begin
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      underrun_q <= underrun_d;
      ur_cnt_q   <= ur_cnt_d;
    end
  end

  assign pwm_out      = !n_rst && (pwm_cnt_q < duty_q);
  assign underrun     = underrun_q;
  assign underrun_cnt = ur_cnt_q;

endmodule

// File: doc/sample_player.md
Name: sample_player

Overview:
- Consumer end of the sample-rate strobe produced by the sample-rate clock divider (`sample_now`, one-cycle pulse every 256 clk).
- Buffers 8-bit unsigned audio samples from the upstream mixer through a valid/ready FIFO.
- Pops one sample per strobe and renders it as single-bit PWM to the board audio pin.
- Flags and counts underruns.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SAMPLE_W, 8, sample and PWM resolution in bits; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock
- n_rst  input  1  reset; synchronous, active-high (asserted = 1, sampled on posedge clk)
- sample_now  input  1  one-cycle sample strobe from the divider
- wr_data  input  8  unsigned sample from the mixer
- wr_valid  input  1  wr_data valid
- wr_ready  output  1  FIFO can accept a push
- fill  output  $clog2(DEPTH+1)  current FIFO occupancy
- pwm_out  output  1  PWM audio output
- underrun  output  1  one-cycle pulse: strobe arrived with FIFO empty
- underrun_cnt  output  8  saturating underrun count

Behaviour:
- Reset (n_rst = 1 at posedge): FIFO empty, fill = 0, duty = 128, pwm_cnt = 0, underrun = 0, underrun_cnt = 0.
  - wr_ready = 0 while n_rst is high.
  - pwm_out = 0 during reset, since it is forced low.
  - Reset mid-operation discards all buffered samples.
- Push:
  - wr_ready = !full && !n_rst, decoded from registered state only.
  - A push occurs when wr_valid && wr_ready at a posedge.
  - wr_data is held by the source until accepted.
- Pop:
  - On a posedge with sample_now = 1 and FIFO not empty, duty <= head entry, the FIFO pops, and fill decrements.
  - The new duty is visible from the next cycle.
- Simultaneous push and pop:
  - When not full and not empty, both occur and fill is unchanged.
  - When full, wr_ready is already 0, so only the pop occurs and wr_ready rises the next cycle.
  - When empty, the push lands in the FIFO and the strobe is an underrun. There is no bypass.
- Underrun (sample_now = 1 with FIFO empty):
  - duty <= 128 (midscale silence).
  - underrun = 1 for exactly the next cycle.
  - underrun_cnt increments, saturating at 255.
- PWM:
  - On sample_now, pwm_cnt <= 0; otherwise pwm_cnt <= pwm_cnt + 1, wrapping 255→0.
  - pwm_out = (pwm_cnt < duty), from registered values with no extra latency.
  - duty 0 gives constant low; duty 255 gives high for 255 of 256 cycles.
  - If strobes arrive at a period other than 256, the counter still restarts at each strobe. A shorter period truncates the PWM frame; a longer one wraps.
- FIFO pointers: log2(DEPTH) bits, wrapping naturally. Full/empty are derived from the fill counter, never from pointer equality alone.
- sample_now asserted during reset is ignored.

Decomposition:
- Shared package `audio_pkg`:
  - SAMPLE_W = 8
  - MIDSCALE = 8'd128
  - typedef `sample_t` as logic [SAMPLE_W-1:0]
  - UNDERRUN_MAX = 8'd255
- One sub-module `sample_fifo`: parameterised DEPTH/WIDTH, synchronous active-high reset, push/pop/full/empty/fill.
- `sample_player` owns the PWM counter, duty register and underrun logic.

Test Plan:
- Reset: hold n_rst = 1 for 3 cycles with wr_valid = 1 and sample_now = 1 → wr_ready = 0, fill = 0, pwm_out = 0, underrun_cnt = 0. After release, wr_ready = 1.
- Basic play: push 8'd64, then strobe → from the next cycle pwm_out is high for exactly 64 of 256 cycles, high first, and fill returns to 0.
- Fill and backpressure (DEPTH = 4): push 10, 20, 30, 40 → fill = 4, wr_ready = 0.
  - A fifth wr_valid is held unaccepted.
  - Strobe → duty = 10, fill = 3, and the held sample is accepted the cycle after.
  - Subsequent strobes yield duties 20, 30, 40 in order.
- Underrun: strobe with FIFO empty → underrun pulses for 1 cycle, duty = 128 (128 high of 256), underrun_cnt = 1.
  - 300 more empty strobes → underrun_cnt = 255.
- Simultaneous events:
  - FIFO holding 1 entry, push 8'd200 on the same posedge as a strobe → duty = head, fill stays 1.
  - Empty FIFO, push with strobe → underrun = 1, fill = 1.
- Extremes and reset mid-play:
  - duty 0 → pwm_out never high; duty 255 → low exactly 1 cycle per frame.
  - Assert n_rst mid-frame with 3 entries queued → FIFO empty, duty = 128 after release.
